display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_if.sv | 9 +
 rtl/display_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// BCD value handshake between a producer and the display scan controller.
interface display_scan_ctrl_if;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;

    modport master (output bcd_in, output bcd_valid, input  bcd_ready);
    modport slave  (input  bcd_in, input  bcd_valid, output bcd_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 3-digit 7-segment scan controller with a one-deep pending buffer
// so a newly accepted value only reaches the display on a frame boundary.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned DEC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   bcd,
    input  logic                 blank_lz,
    output logic [DEC_WIDTH-1:0] digit_sel,
    output logic [6:0]           seg_n,
    output logic                 tick
);

    localparam int unsigned PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    localparam logic [DEC_WIDTH-1:0] DIG_ONES = DEC_WIDTH'(0);
    localparam logic [DEC_WIDTH-1:0] DIG_TENS = DEC_WIDTH'(1);
    localparam logic [DEC_WIDTH-1:0] DIG_HUND = DEC_WIDTH'(2);
    localparam logic [DEC_WIDTH-1:0] DIG_NONE = DEC_WIDTH'(3);

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    logic [PRE_W-1:0]     presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic [DEC_WIDTH-1:0] dsel_q, dsel_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 ready_q, ready_d;
    logic                 pend_full_q, pend_full_d;
    logic [BCD_W-1:0]     pend_val_q, pend_val_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic                 xfer_c;
    logic                 boundary_c;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [SEG_W-1:0] seg_of(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] s;
        s = SEG_DASH;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Prescaler, digit sequencing and the pending/display buffer pair.
    always_comb begin
        presc_d     = presc_q;
        tick_d      = 1'b0;
        dsel_d      = dsel_q;
        boundary_c  = 1'b0;
        xfer_c      = 1'b0;
        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        disp_d      = disp_q;
        ready_d     = ready_q;

        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
        tick_d  = (presc_d == PRE_LAST);

        if (tick_q) begin
            case (dsel_q)
                DIG_NONE: begin
                    dsel_d     = DIG_ONES;
                    boundary_c = 1'b1;
                end
                DIG_ONES: dsel_d = DIG_TENS;
                DIG_TENS: dsel_d = DIG_HUND;
                DIG_HUND: begin
                    dsel_d     = DIG_ONES;
                    boundary_c = 1'b1;
                end
                default: begin
                    dsel_d     = DIG_ONES;
                    boundary_c = 1'b1;
                end
            endcase
        end

        // Old pending value moves to the display before a same-edge transfer refills it.
        if (boundary_c && pend_full_q) begin
            disp_d      = pend_val_q;
            pend_full_d = 1'b0;
        end

        xfer_c = bcd.bcd_valid && !pend_full_q;
        if (xfer_c) begin
            pend_val_d  = bcd.bcd_in;
            pend_full_d = 1'b1;
        end

        ready_d = !pend_full_d;
    end

    // Segment pattern for the digit that becomes active on this edge.
    always_comb begin
        logic [NIB_W-1:0] ones, tens, hund;
        ones  = disp_d[3:0];
        tens  = disp_d[7:4];
        hund  = disp_d[11:8];
        seg_d = SEG_BLANK;
        case (dsel_d)
            DIG_ONES: seg_d = seg_of(ones);
            DIG_TENS: seg_d = (blank_lz && hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_of(tens);
            DIG_HUND: seg_d = (blank_lz && hund == 4'd0) ? SEG_BLANK : seg_of(hund);
            default:  seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            dsel_q      <= DIG_NONE;
            seg_q       <= SEG_BLANK;
            ready_q     <= 1'b1;
            pend_full_q <= 1'b0;
            pend_val_q  <= '0;
            disp_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            dsel_q      <= dsel_d;
            seg_q       <= seg_d;
            ready_q     <= ready_d;
            pend_full_q <= pend_full_d;
            pend_val_q  <= pend_val_d;
            disp_q      <= disp_d;
        end
    end

    assign digit_sel     = dsel_q;
    assign seg_n         = seg_q;
    assign tick          = tick_q;
    assign bcd.bcd_ready = ready_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at CLK_DIV=4: expectations are queued
// per cycle-after-reset and checked by an independent negedge monitor.
module tb_display_scan_ctrl;

    localparam logic [1:0] K_SEG  = 2'd0;
    localparam logic [1:0] K_TICK = 2'd1;
    localparam logic [1:0] K_RDY  = 2'd2;

    typedef struct packed {
        int          cyc;
        logic [1:0]  kind;
        logic [15:0] exp;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blank_lz = 1'b0;
    logic [1:0] digit_sel;
    logic [6:0] seg_n;
    logic       tick;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    item_t exp_q[$];
    string name_q[$];

    item_t       mon_it;
    string       mon_nm;
    logic [15:0] mon_got;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.CLK_DIV(4), .DEC_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd       (bus),
        .blank_lz  (blank_lz),
        .digit_sel (digit_sel),
        .seg_n     (seg_n),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Cycle 1 is the first cycle after the reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 1;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_it = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            checks++;
            if (mon_it.cyc < cyc) begin
                failures++;
                $display("FAIL %s not observed at cyc %0d (now cyc %0d)", mon_nm, mon_it.cyc, cyc);
            end else begin
                case (mon_it.kind)
                    K_SEG:   mon_got = 16'({digit_sel, seg_n});
                    K_TICK:  mon_got = 16'(tick);
                    default: mon_got = 16'(bus.bcd_ready);
                endcase
                if (mon_got !== mon_it.exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", mon_nm, cyc, mon_got, mon_it.exp);
                end
            end
        end
    end

    task automatic push(input int c, input logic [1:0] k, input logic [15:0] e, input string nm);
        item_t it;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        exp_q.push_back(it);
        name_q.push_back(nm);
    endtask

    task automatic exp_seg(input int c, input logic [1:0] d, input logic [6:0] s, input string nm);
        push(c, K_SEG, 16'({d, s}), nm);
    endtask

    task automatic exp_tick(input int c, input logic v, input string nm);
        push(c, K_TICK, 16'(v), nm);
    endtask

    task automatic exp_rdy(input int c, input logic v, input string nm);
        push(c, K_RDY, 16'(v), nm);
    endtask

    task automatic do_reset(input logic offer, input logic [11:0] v);
        rst           = 1'b1;
        bus.bcd_valid = offer;
        bus.bcd_in    = v;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.bcd_valid = 1'b0;
    endtask

    task automatic send(input logic [11:0] v);
        bus.bcd_in    = v;
        bus.bcd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bcd_valid = 1'b0;
    endtask

    task automatic go_cyc(input int n);
        int k;
        k = 0;
        while (cyc < n && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        while (exp_q.size() > 0) begin
            mon_it = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s timed out waiting for cyc %0d", mon_nm, mon_it.cyc);
        end
    endtask

    initial begin
        bus.bcd_in    = 12'h000;
        bus.bcd_valid = 1'b0;

        // Idle scan after reset
        do_reset(1'b0, 12'h000);
        exp_seg (1, 2'd3, 7'h7F, "rst_seg");
        exp_tick(1, 1'b0, "rst_tick");
        exp_rdy (1, 1'b1, "rst_ready");
        exp_tick(3, 1'b0, "idle_tick3");
        exp_tick(4, 1'b1, "idle_tick4");
        exp_tick(5, 1'b0, "idle_tick5");
        exp_seg (5, 2'd0, 7'h40, "idle_ones");
        exp_tick(8, 1'b1, "idle_tick8");
        exp_seg (9, 2'd1, 7'h40, "idle_tens");
        exp_tick(12, 1'b1, "idle_tick12");
        exp_seg (13, 2'd2, 7'h40, "idle_hund");
        go_cyc(14);
        drain();

        // Accept 0x297, refuse 0x555 while full
        do_reset(1'b0, 12'h000);
        exp_rdy (1, 1'b1, "hs_ready1");
        exp_rdy (2, 1'b0, "hs_ready2");
        exp_rdy (3, 1'b0, "hs_ready3");
        exp_seg (5, 2'd0, 7'h78, "hs_ones");
        exp_rdy (5, 1'b1, "hs_ready5");
        exp_seg (9, 2'd1, 7'h10, "hs_tens");
        exp_seg (13, 2'd2, 7'h24, "hs_hund");
        exp_seg (17, 2'd0, 7'h78, "hs_ones_f2");
        send(12'h297);
        send(12'h555);
        drain();

        // Leading-zero blanking of 0x007, then blanking off mid-frame
        do_reset(1'b0, 12'h000);
        blank_lz = 1'b1;
        exp_seg (5, 2'd0, 7'h78, "lz_ones");
        exp_seg (9, 2'd1, 7'h7F, "lz_tens_blank");
        exp_seg (13, 2'd2, 7'h7F, "lz_hund_blank");
        exp_seg (17, 2'd0, 7'h78, "lz_ones_f2");
        exp_seg (21, 2'd1, 7'h40, "lz_tens_off");
        exp_seg (25, 2'd2, 7'h40, "lz_hund_off");
        send(12'h007);
        go_cyc(18);
        blank_lz = 1'b0;
        drain();

        // Dash digits are never blanked; 0x000 keeps its ones digit
        do_reset(1'b0, 12'h000);
        blank_lz = 1'b1;
        exp_seg (5, 2'd0, 7'h12, "dash_ones");
        exp_seg (9, 2'd1, 7'h3F, "dash_tens");
        exp_seg (13, 2'd2, 7'h7F, "dash_hund_blank");
        exp_seg (17, 2'd0, 7'h40, "zero_ones");
        exp_seg (21, 2'd1, 7'h7F, "zero_tens");
        exp_seg (25, 2'd2, 7'h7F, "zero_hund");
        exp_seg (29, 2'd0, 7'h40, "f00_ones");
        exp_seg (33, 2'd1, 7'h40, "f00_tens");
        exp_seg (37, 2'd2, 7'h3F, "f00_hund");
        send(12'h0B5);
        go_cyc(6);
        send(12'h000);
        go_cyc(18);
        send(12'hF00);
        drain();
        blank_lz = 1'b0;

        // New value offered across the 2->0 boundary while 0x123 is pending
        do_reset(1'b0, 12'h000);
        exp_seg (5, 2'd0, 7'h40, "pb_ones0");
        exp_seg (9, 2'd1, 7'h00, "pb_tens8");
        exp_seg (13, 2'd2, 7'h10, "pb_hund9");
        exp_rdy (16, 1'b0, "pb_ready16");
        exp_seg (17, 2'd0, 7'h30, "pb_123_ones");
        exp_rdy (18, 1'b0, "pb_ready18");
        exp_seg (21, 2'd1, 7'h24, "pb_123_tens");
        exp_seg (25, 2'd2, 7'h79, "pb_123_hund");
        exp_rdy (28, 1'b0, "pb_ready28");
        exp_seg (29, 2'd0, 7'h02, "pb_456_ones");
        exp_rdy (29, 1'b1, "pb_ready29");
        exp_seg (33, 2'd1, 7'h12, "pb_456_tens");
        exp_seg (37, 2'd2, 7'h19, "pb_456_hund");
        send(12'h980);
        go_cyc(5);
        send(12'h123);
        go_cyc(16);
        bus.bcd_in    = 12'h456;
        bus.bcd_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.bcd_valid = 1'b0;
        drain();

        // Mid-frame reset with a value offered in the reset cycle
        do_reset(1'b0, 12'h000);
        exp_seg (9, 2'd1, 7'h12, "mr_tens_pre");
        send(12'h456);
        go_cyc(10);
        drain();
        do_reset(1'b1, 12'h888);
        exp_seg (1, 2'd3, 7'h7F, "mr_seg");
        exp_tick(1, 1'b0, "mr_tick");
        exp_rdy (1, 1'b1, "mr_ready");
        exp_tick(4, 1'b1, "mr_tick4");
        exp_seg (5, 2'd0, 7'h40, "mr_ones");
        exp_seg (9, 2'd1, 7'h40, "mr_tens");
        exp_seg (17, 2'd0, 7'h40, "mr_ones_f2");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
